// File: rtl/usb_tx_bit_stuffer.sv
// usb_tx_bit_stuffer
// Transmit serializer and bit stuffer feeding the NRZI encoder. Packet bytes
// arrive over a valid/ready handshake and leave LSB-first, one bit per DPLL
// pulse. A 0 is inserted after every run of STUFF_RUN consecutive 1s.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   pulse           one-cycle bit strobe; one line bit per pulse
//   byte_data       byte to transmit (LSB first)
//   byte_valid      byte_data/byte_last valid
//   byte_last       marks the final byte of the packet
//   byte_ready      block accepts a byte this cycle
//   curr_bit        bit presented to the NRZI encoder
//   start_encoding  high for the whole packet, including a trailing stuff bit
//   tx_busy         high whenever not idle
//   tx_done         one-cycle pulse at packet end
//   tx_err          one-cycle pulse on underrun (together with tx_done)
module usb_tx_bit_stuffer #(
    parameter int DATA_W    = 8,
    parameter int STUFF_RUN = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse,
    input  logic [DATA_W-1:0] byte_data,
    input  logic              byte_valid,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic              curr_bit,
    output logic              start_encoding,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              tx_err
);

    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int ONES_W = $clog2(STUFF_RUN + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, STUFF, DONE} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                hold_vld_q, hold_vld_d;
    logic                hold_last_q, hold_last_d;
    logic                cur_last_q, cur_last_d;   // byte in shreg is the last one
    logic                last_seen_q, last_seen_d; // byte_last accepted this packet
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [ONES_W-1:0]   ones_cnt_q, ones_cnt_d;
    logic                defer_q, defer_d;         // byte boundary postponed past a stuff bit
    logic                err_q, err_d;

    logic accept;
    logic boundary;
    logic resolve;

    function automatic logic [ONES_W-1:0] sat_inc(input logic [ONES_W-1:0] v);
        if (v == ONES_W'(STUFF_RUN)) begin
            return v;
        end
        return v + ONES_W'(1);
    endfunction

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        hold_last_d = hold_last_q;
        cur_last_d  = cur_last_q;
        last_seen_d = last_seen_q;
        bit_cnt_d   = bit_cnt_q;
        ones_cnt_d  = ones_cnt_q;
        defer_d     = defer_q;
        err_d       = err_q;
        resolve     = 1'b0;

        byte_ready     = !hold_vld_q && !last_seen_q && (state_q != DONE);
        accept         = byte_valid && byte_ready;
        boundary       = (bit_cnt_q == CNT_W'(DATA_W - 1));
        curr_bit       = 1'b1;
        start_encoding = 1'b0;
        tx_busy        = (state_q != IDLE);
        tx_done        = (state_q == DONE);
        tx_err         = (state_q == DONE) && err_q;

        // Outside IDLE an accepted byte parks in the holding register; a
        // boundary resolution below may redirect it straight into shreg.
        if (accept && state_q != IDLE) begin
            hold_d      = byte_data;
            hold_vld_d  = 1'b1;
            hold_last_d = byte_last;
            last_seen_d = last_seen_q | byte_last;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d     = byte_data;
                    cur_last_d  = byte_last;
                    last_seen_d = byte_last;
                    bit_cnt_d   = '0;
                    ones_cnt_d  = '0;
                    defer_d     = 1'b0;
                    err_d       = 1'b0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                curr_bit       = shreg_q[0];
                start_encoding = 1'b1;
                if (pulse) begin
                    ones_cnt_d = shreg_q[0] ? sat_inc(ones_cnt_q) : '0;
                    shreg_d    = shreg_q >> 1;
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    if (shreg_q[0] && ones_cnt_q == ONES_W'(STUFF_RUN - 1)) begin
                        state_d = STUFF;
                        defer_d = boundary;
                    end else if (boundary) begin
                        resolve = 1'b1;
                    end
                end
            end
            STUFF: begin
                curr_bit       = 1'b0;
                start_encoding = 1'b1;
                if (pulse) begin
                    ones_cnt_d = '0;
                    defer_d    = 1'b0;
                    if (defer_q) begin
                        resolve = 1'b1;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            DONE: begin
                state_d     = IDLE;
                last_seen_d = 1'b0;
                hold_vld_d  = 1'b0;
                err_d       = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // Byte boundary: finish the packet, load the next byte, or underrun.
        if (resolve) begin
            bit_cnt_d = '0;
            if (cur_last_q) begin
                state_d = DONE;
            end else if (hold_vld_q) begin
                shreg_d    = hold_q;
                cur_last_d = hold_last_q;
                hold_vld_d = accept;
                state_d    = SHIFT;
            end else if (accept) begin
                shreg_d    = byte_data;
                cur_last_d = byte_last;
                hold_vld_d = 1'b0;
                state_d    = SHIFT;
            end else begin
                err_d   = 1'b1;
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            hold_q      <= '0;
            hold_vld_q  <= 1'b0;
            hold_last_q <= 1'b0;
            cur_last_q  <= 1'b0;
            last_seen_q <= 1'b0;
            bit_cnt_q   <= '0;
            ones_cnt_q  <= '0;
            defer_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            hold_last_q <= hold_last_d;
            cur_last_q  <= cur_last_d;
            last_seen_q <= last_seen_d;
            bit_cnt_q   <= bit_cnt_d;
            ones_cnt_q  <= ones_cnt_d;
            defer_q     <= defer_d;
            err_q       <= err_d;
        end
    end

endmodule
